alu_issue: RTL and testbench

Register-file and issue sequencer sitting directly upstream of `alu`. It accepts R-type commands over a valid/ready handshake, reads two source registers from an internal register file, and drives `alu` operands and opcode from registers. It captures the ALU result and flags, writes the result back to the destination register, and returns it on a valid/ready response port. A load-immediate command path initialises registers.

---
 rtl/alu_issue.sv | 203 ++++++++++++++++++++
 tb/tb_alu_issue.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: register file and issue sequencer feeding the alu block.
// Accepts R-type and load-immediate commands, reads operands, drives the
// ALU from registers, captures result/flags, writes back and returns a
// response. Optional build macro: ALU_ISSUE_OVF_TRAP_EN suppresses the
// writeback of ADD/SUB results that overflow.
module alu_issue #(
    parameter int NREGS = 32,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_ld,
    input  logic [2:0]   cmd_op,
    input  logic [4:0]   cmd_rd,
    input  logic [4:0]   cmd_rs,
    input  logic [4:0]   cmd_rt,
    input  logic [4:0]   cmd_shamt,
    input  logic [W-1:0] cmd_imm,
    output logic [W-1:0] alu_x,
    output logic [W-1:0] alu_y,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_z,
    input  logic         alu_equal,
    input  logic         alu_overflow,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic [2:0]   rsp_flags,
    input  logic [4:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);

    // Opcode encoding shared with the alu block.
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_SLL = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;
    localparam logic [2:0] ALU_SRA = 3'd6;

    // The index space is the full 5-bit range; entries at or above NREGS
    // (and entry 0) are hard-wired to zero so they read 0 and drop writes.
    localparam int NIDX = 32;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_RESP} state_t;

    state_t         state_reg, state_next;

    logic           accept;
    logic [2:0]     op_reg;
    logic [4:0]     rd_reg, rs_reg, rt_reg, shamt_reg;
    logic [W-1:0]   alu_x_reg, alu_y_reg;
    logic [2:0]     alu_op_reg;
    logic [W-1:0]   rsp_data_reg;
    logic [2:0]     rsp_flags_reg;
    logic           is_shift;
    logic           trap;

    logic           wr_en;
    logic [4:0]     wr_idx;
    logic [W-1:0]   wr_data;
    logic [W-1:0]   rf_q [NIDX];

    assign accept   = cmd_valid && cmd_ready;
    assign is_shift = (op_reg == ALU_SLL) || (op_reg == ALU_SRL) || (op_reg == ALU_SRA);

`ifdef ALU_ISSUE_OVF_TRAP_EN
    assign trap = alu_overflow && ((op_reg == ALU_ADD) || (op_reg == ALU_SUB));
`else
    assign trap = 1'b0;
`endif

    // Register file: one flop word per implemented index, cleared on reset.
    genvar gi;
    generate
        for (gi = 0; gi < NIDX; gi++) begin : g_rf
            if ((gi != 0) && (gi < NREGS)) begin : g_reg
                logic [W-1:0] q_reg;
                // Write the selected word; reset clears it immediately.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= '0;
                    end else if (wr_en && (wr_idx == 5'(gi))) begin
                        q_reg <= wr_data;
                    end
                end
                assign rf_q[gi] = q_reg;
            end else begin : g_zero
                assign rf_q[gi] = '0;
            end
        end
    endgenerate

    assign dbg_data = rf_q[dbg_addr];

    // Single write port: load-immediate on accept, ALU result in EXEC.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        if ((state_reg == S_IDLE) && accept && cmd_ld) begin
            wr_en   = 1'b1;
            wr_idx  = cmd_rd;
            wr_data = cmd_imm;
        end else if (state_reg == S_EXEC) begin
            wr_en   = !trap;
            wr_idx  = rd_reg;
            wr_data = alu_z;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> READ -> EXEC -> RESP for ALU ops, IDLE -> RESP for loads.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = cmd_ld ? S_RESP : S_READ;
                end
            end
            S_READ:  state_next = S_EXEC;
            S_EXEC:  state_next = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        cmd_ready = (state_reg == S_IDLE) && rst_n;
        rsp_valid = (state_reg == S_RESP);
    end

    // Datapath: command latch, operand registers and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg        <= '0;
            rd_reg        <= '0;
            rs_reg        <= '0;
            rt_reg        <= '0;
            shamt_reg     <= '0;
            alu_x_reg     <= '0;
            alu_y_reg     <= '0;
            alu_op_reg    <= '0;
            rsp_data_reg  <= '0;
            rsp_flags_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept && !cmd_ld) begin
                        op_reg    <= cmd_op;
                        rd_reg    <= cmd_rd;
                        rs_reg    <= cmd_rs;
                        rt_reg    <= cmd_rt;
                        shamt_reg <= cmd_shamt;
                    end else if (accept && cmd_ld) begin
                        rsp_data_reg  <= cmd_imm;
                        rsp_flags_reg <= 3'b000;
                    end
                end
                S_READ: begin
                    // Shifts take the value from rt and the amount from shamt.
                    alu_op_reg <= op_reg;
                    if (is_shift) begin
                        alu_x_reg <= rf_q[rt_reg];
                        alu_y_reg <= {{(W-5){1'b0}}, shamt_reg};
                    end else begin
                        alu_x_reg <= rf_q[rs_reg];
                        alu_y_reg <= rf_q[rt_reg];
                    end
                end
                S_EXEC: begin
                    // Response always carries the ALU result, even if the write is dropped.
                    rsp_data_reg  <= alu_z;
                    rsp_flags_reg <= {alu_equal, alu_overflow, alu_zero};
                end
                default: ;
            endcase
        end
    end

    assign alu_x     = alu_x_reg;
    assign alu_y     = alu_y_reg;
    assign alu_op    = alu_op_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_flags = rsp_flags_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: table of directed commands with hand-computed
// results, plus back-pressure and mid-command reset sequences. A small
// behavioural alu stands in for the real one.
module tb_alu_issue;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLL = 3'd4;
    localparam logic [2:0] OP_SRL = 3'd5;
    localparam logic [2:0] OP_SRA = 3'd6;
    localparam logic [2:0] OP_UNK = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_ld;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_rd, cmd_rs, cmd_rt, cmd_shamt;
    logic [31:0] cmd_imm;
    logic [31:0] alu_x, alu_y, alu_z;
    logic [2:0]  alu_op;
    logic        alu_equal, alu_overflow, alu_zero;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_flags;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue #(.NREGS(32), .W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .cmd_shamt(cmd_shamt), .cmd_imm(cmd_imm),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_z(alu_z), .alu_equal(alu_equal), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural alu; opcode 7 is unimplemented and returns a fixed pattern.
    always_comb begin
        alu_z        = 32'h0;
        alu_overflow = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_z        = alu_x + alu_y;
                alu_overflow = (alu_x[31] == alu_y[31]) && (alu_z[31] != alu_x[31]);
            end
            OP_SUB: begin
                alu_z        = alu_x - alu_y;
                alu_overflow = (alu_x[31] != alu_y[31]) && (alu_z[31] != alu_x[31]);
            end
            OP_AND:  alu_z = alu_x & alu_y;
            OP_OR:   alu_z = alu_x | alu_y;
            OP_SLL:  alu_z = alu_x << alu_y[4:0];
            OP_SRL:  alu_z = alu_x >> alu_y[4:0];
            OP_SRA:  alu_z = $unsigned($signed(alu_x) >>> alu_y[4:0]);
            default: alu_z = 32'hDEADBEEF;
        endcase
        alu_equal = (alu_x == alu_y);
        alu_zero  = (alu_z == 32'h0);
    end

    typedef struct {
        logic        ld;
        logic [2:0]  op;
        logic [4:0]  rd, rs, rt, shamt;
        logic [31:0] imm;
        logic [31:0] exp_data;
        logic [2:0]  exp_flags;
        logic [31:0] exp_x, exp_y;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

`ifdef ALU_ISSUE_OVF_TRAP_EN
    localparam logic [31:0] EXP_R6 = 32'h0;
`else
    localparam logic [31:0] EXP_R6 = 32'hD5555554;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk_ld(input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] exp_rd);
        vec_t v;
        v.ld = 1'b1; v.op = 3'd0; v.rd = rd; v.rs = 5'd0; v.rt = 5'd0; v.shamt = 5'd0;
        v.imm = imm; v.exp_data = imm; v.exp_flags = 3'b000;
        v.exp_x = 32'h0; v.exp_y = 32'h0; v.exp_rd = exp_rd;
        return v;
    endfunction

    function automatic vec_t mk_op(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [4:0] shamt,
                                   input logic [31:0] ex, input logic [31:0] ey,
                                   input logic [31:0] ed, input logic [2:0] ef, input logic [31:0] er);
        vec_t v;
        v.ld = 1'b0; v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.shamt = shamt;
        v.imm = 32'h0; v.exp_data = ed; v.exp_flags = ef;
        v.exp_x = ex; v.exp_y = ey; v.exp_rd = er;
        return v;
    endfunction

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = 3'd0;
        cmd_rd = 5'd0; cmd_rs = 5'd0; cmd_rt = 5'd0; cmd_shamt = 5'd0; cmd_imm = 32'h0;
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_valid = 1'b1; cmd_ld = v.ld; cmd_op = v.op;
        cmd_rd = v.rd; cmd_rs = v.rs; cmd_rt = v.rt; cmd_shamt = v.shamt; cmd_imm = v.imm;
    endtask

    // Bounded wait at negedges for cmd_ready; returns 1 if seen.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // Issue one command with rsp_ready held high and check response and writeback.
    task automatic run_vec(input int idx, input vec_t v);
        bit ok;
        wait_ready(ok);
        check("cmd_ready_timeout", {31'b0, ok}, 32'h1);
        drive_cmd(v);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        wait_rsp(ok);
        check("rsp_valid_timeout", {31'b0, ok}, 32'h1);
        check("rsp_data", rsp_data, v.exp_data);
        check("rsp_flags", {29'b0, rsp_flags}, {29'b0, v.exp_flags});
        if (!v.ld) begin
            check("alu_x", alu_x, v.exp_x);
            check("alu_y", alu_y, v.exp_y);
            check("alu_op", {29'b0, alu_op}, {29'b0, v.op});
        end
        @(negedge clk);
        dbg_addr = v.rd;
        #1;
        check("writeback", dbg_data, v.exp_rd);
        $display("txn %0d ld=%0b op=%0d rd=%0d rs=%0d rt=%0d -> data=%08h flags=%03b R[rd]=%08h",
                 idx, v.ld, v.op, v.rd, v.rs, v.rt, rsp_data, rsp_flags, dbg_data);
    endtask

    task automatic sweep_zero(input string name);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            check(name, dbg_data, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vb;
        bit   ok;

        vecs[0]  = mk_ld(5'd1, 32'h000000FF, 32'h000000FF);
        vecs[1]  = mk_ld(5'd2, 32'h000000FF, 32'h000000FF);
        vecs[2]  = mk_op(OP_ADD, 5'd3, 5'd1, 5'd2, 5'd0, 32'hFF, 32'hFF, 32'h000001FE, 3'b100, 32'h000001FE);
        vecs[3]  = mk_ld(5'd4, 32'h7FFFFFFF, 32'h7FFFFFFF);
        vecs[4]  = mk_ld(5'd5, 32'h55555555, 32'h55555555);
        vecs[5]  = mk_op(OP_ADD, 5'd6, 5'd4, 5'd5, 5'd0, 32'h7FFFFFFF, 32'h55555555, 32'hD5555554, 3'b010, EXP_R6);
        vecs[6]  = mk_op(OP_SUB, 5'd0, 5'd1, 5'd2, 5'd0, 32'hFF, 32'hFF, 32'h0, 3'b101, 32'h0);
        vecs[7]  = mk_op(OP_SLL, 5'd7, 5'd3, 5'd1, 5'd4, 32'hFF, 32'h4, 32'h00000FF0, 3'b000, 32'h00000FF0);
        vecs[8]  = mk_ld(5'd10, 32'h80000000, 32'h80000000);
        vecs[9]  = mk_op(OP_SRA, 5'd9, 5'd0, 5'd10, 5'd4, 32'h80000000, 32'h4, 32'hF8000000, 3'b000, 32'hF8000000);
        vecs[10] = mk_op(OP_SRL, 5'd12, 5'd0, 5'd10, 5'd31, 32'h80000000, 32'h1F, 32'h1, 3'b000, 32'h1);
        vecs[11] = mk_op(OP_UNK, 5'd11, 5'd1, 5'd2, 5'd0, 32'hFF, 32'hFF, 32'hDEADBEEF, 3'b100, 32'hDEADBEEF);
        vecs[12] = mk_ld(5'd0, 32'h00001234, 32'h0);
        vecs[13] = mk_op(OP_AND, 5'd13, 5'd3, 5'd1, 5'd0, 32'h1FE, 32'hFF, 32'hFE, 3'b000, 32'hFE);

        // Reset state.
        rst_n = 1'b0; rsp_ready = 1'b0; dbg_addr = 5'd0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_alu_x", alu_x, 32'h0);
        check("rst_alu_y", alu_y, 32'h0);
        check("rst_alu_op", {29'b0, alu_op}, 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_flags", {29'b0, rsp_flags}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("cmd_ready_after_rst", {31'b0, cmd_ready}, 32'h1);
        sweep_zero("rst_sweep");
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-pressure: response held 5 cycles with a load queued behind it.
        @(negedge clk);
        vb = mk_op(OP_ADD, 5'd14, 5'd1, 5'd2, 5'd0, 32'hFF, 32'hFF, 32'h1FE, 3'b100, 32'h1FE);
        rsp_ready = 1'b0;
        drive_cmd(vb);
        @(posedge clk);
        #1;
        cmd_ld = 1'b1; cmd_rd = 5'd15; cmd_imm = 32'h0000ABCD;
        @(negedge clk);
        wait_rsp(ok);
        check("bp_rsp_timeout", {31'b0, ok}, 32'h1);
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
            check("bp_rsp_data", rsp_data, 32'h1FE);
            check("bp_rsp_flags", {29'b0, rsp_flags}, 32'h4);
            check("bp_cmd_ready", {31'b0, cmd_ready}, 32'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_after_fire", {31'b0, cmd_ready}, 32'h1);
        check("bp_valid_after_fire", {31'b0, rsp_valid}, 32'h0);
        dbg_addr = 5'd15;
        #1;
        check("bp_r15_not_yet", dbg_data, 32'h0);
        @(negedge clk);
        check("bp_second_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        check("bp_second_rsp_data", rsp_data, 32'h0000ABCD);
        check("bp_r15", dbg_data, 32'h0000ABCD);
        idle_inputs();
        $display("txn bp: first=%08h second=%08h", 32'h1FE, rsp_data);
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset asserted while an ADD rd=8 is in EXEC.
        @(negedge clk);
        vb = mk_op(OP_ADD, 5'd8, 5'd1, 5'd2, 5'd0, 32'hFF, 32'hFF, 32'h1FE, 3'b100, 32'h0);
        rsp_ready = 1'b1;
        drive_cmd(vb);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        check("mid_rst_alu_x", alu_x, 32'h0);
        check("mid_rst_rsp_data", rsp_data, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dbg_addr = 5'd8;
        #1;
        check("mid_rst_r8", dbg_data, 32'h0);
        check("mid_rst_ready", {31'b0, cmd_ready}, 32'h1);
        sweep_zero("mid_rst_sweep");
        @(negedge clk);
        check("mid_rst_no_rsp", {31'b0, rsp_valid}, 32'h0);
        $display("txn reset-in-exec: R8=%08h rsp_valid=%0b", dbg_data, rsp_valid);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
